// File: rtl/axis_atomic_fi_if.sv
// Signal bundle for the two-channel fan-in: two input streams and one combined output stream.
// The slave modport is the fan-in's own view; master is the view of whatever drives and drains it.
interface axis_atomic_fi_if #(
    parameter int CHA_BITS = 8,
    parameter int CHB_BITS = 8
);
    logic                         s_axis_cha_tready;
    logic                         s_axis_cha_tvalid;
    logic [CHA_BITS-1:0]          s_axis_cha_tdata;
    logic                         s_axis_chb_tready;
    logic                         s_axis_chb_tvalid;
    logic [CHB_BITS-1:0]          s_axis_chb_tdata;
    logic                         m_axis_comb_tready;
    logic                         m_axis_comb_tvalid;
    logic [CHA_BITS+CHB_BITS-1:0] m_axis_comb_tdata;
    logic [1:0]                   m_axis_comb_tuser;

    modport slave (
        output s_axis_cha_tready,
        input  s_axis_cha_tvalid, s_axis_cha_tdata,
        output s_axis_chb_tready,
        input  s_axis_chb_tvalid, s_axis_chb_tdata,
        input  m_axis_comb_tready,
        output m_axis_comb_tvalid, m_axis_comb_tdata, m_axis_comb_tuser
    );

    modport master (
        input  s_axis_cha_tready,
        output s_axis_cha_tvalid, s_axis_cha_tdata,
        input  s_axis_chb_tready,
        output s_axis_chb_tvalid, s_axis_chb_tdata,
        output m_axis_comb_tready,
        input  m_axis_comb_tvalid, m_axis_comb_tdata, m_axis_comb_tuser
    );
endinterface

// File: rtl/axis_atomic_fi.sv
// Two-channel AXI-Stream fan-in: pairs channel A/B words into {chb,cha} with a presence mask,
// emitting a lone word by itself once it has waited WAIT_CYCLES for its partner.
module axis_atomic_fi #(
    parameter int CHA_BITS    = 8,
    parameter int CHB_BITS    = 8,
    parameter int WAIT_CYCLES = 4,
    parameter int WAIT_BITS   = 8,
    parameter int STAT_BITS   = 16
) (
    input  logic                 s_ul_clk,
    input  logic                 reset,
    axis_atomic_fi_if.slave      bus,
    output logic [STAT_BITS-1:0] stat_partial_cnt
);

    localparam int                   COMB_BITS = CHA_BITS + CHB_BITS;
    localparam logic [WAIT_BITS-1:0] WAIT_MAX  = WAIT_BITS'(WAIT_CYCLES);
    localparam logic [STAT_BITS-1:0] STAT_MAX  = {STAT_BITS{1'b1}};

    logic                 hold_a_v_q, hold_a_v_d;
    logic [CHA_BITS-1:0]  hold_a_d_q, hold_a_d_d;
    logic                 hold_b_v_q, hold_b_v_d;
    logic [CHB_BITS-1:0]  hold_b_d_q, hold_b_d_d;
    logic [WAIT_BITS-1:0] wait_cnt_q, wait_cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic [COMB_BITS-1:0] out_data_q, out_data_d;
    logic [1:0]           out_user_q, out_user_d;
    logic [STAT_BITS-1:0] stat_q, stat_d;
    logic                 out_free_s;
    logic                 lone_s;
    logic                 go_s;

    // Next-state logic for holds, wait counter, output register and statistics.
    always_comb begin
        out_free_s = ~out_valid_q | bus.m_axis_comb_tready;
        lone_s     = hold_a_v_q ^ hold_b_v_q;
        go_s       = out_free_s & ((hold_a_v_q & hold_b_v_q) | (lone_s & (wait_cnt_q == WAIT_MAX)));

        hold_a_v_d  = hold_a_v_q;
        hold_a_d_d  = hold_a_d_q;
        hold_b_v_d  = hold_b_v_q;
        hold_b_d_d  = hold_b_d_q;
        wait_cnt_d  = wait_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_user_d  = out_user_q;
        stat_d      = stat_q;

        // A hold being emitted has tready low this cycle, so it cannot also load.
        if (go_s && hold_a_v_q) begin
            hold_a_v_d = 1'b0;
        end else if (bus.s_axis_cha_tvalid && !hold_a_v_q) begin
            hold_a_v_d = 1'b1;
            hold_a_d_d = bus.s_axis_cha_tdata;
        end else begin
            hold_a_v_d = hold_a_v_q;
        end

        if (go_s && hold_b_v_q) begin
            hold_b_v_d = 1'b0;
        end else if (bus.s_axis_chb_tvalid && !hold_b_v_q) begin
            hold_b_v_d = 1'b1;
            hold_b_d_d = bus.s_axis_chb_tdata;
        end else begin
            hold_b_v_d = hold_b_v_q;
        end

        if (go_s || !lone_s) begin
            wait_cnt_d = {WAIT_BITS{1'b0}};
        end else if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + WAIT_BITS'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end

        if (go_s) begin
            out_valid_d = 1'b1;
            out_data_d  = {hold_b_v_q ? hold_b_d_q : {CHB_BITS{1'b0}},
                           hold_a_v_q ? hold_a_d_q : {CHA_BITS{1'b0}}};
            out_user_d  = {hold_b_v_q, hold_a_v_q};
        end else if (bus.m_axis_comb_tready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (go_s && lone_s && (stat_q != STAT_MAX)) begin
            stat_d = stat_q + STAT_BITS'(1);
        end else begin
            stat_d = stat_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge s_ul_clk) begin
        if (reset) begin
            hold_a_v_q  <= 1'b0;
            hold_a_d_q  <= {CHA_BITS{1'b0}};
            hold_b_v_q  <= 1'b0;
            hold_b_d_q  <= {CHB_BITS{1'b0}};
            wait_cnt_q  <= {WAIT_BITS{1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {COMB_BITS{1'b0}};
            out_user_q  <= 2'b00;
            stat_q      <= {STAT_BITS{1'b0}};
        end else begin
            hold_a_v_q  <= hold_a_v_d;
            hold_a_d_q  <= hold_a_d_d;
            hold_b_v_q  <= hold_b_v_d;
            hold_b_d_q  <= hold_b_d_d;
            wait_cnt_q  <= wait_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_user_q  <= out_user_d;
            stat_q      <= stat_d;
        end
    end

    assign bus.s_axis_cha_tready  = ~hold_a_v_q;
    assign bus.s_axis_chb_tready  = ~hold_b_v_q;
    assign bus.m_axis_comb_tvalid = out_valid_q;
    assign bus.m_axis_comb_tdata  = out_data_q;
    assign bus.m_axis_comb_tuser  = out_user_q;
    assign stat_partial_cnt       = stat_q;

endmodule
